// File: rtl/resync_bit_sampler.sv
// resync_bit_sampler
//   Oversampling serial bit recovery: synchronises raw_data, tracks the bit
//   phase on each sample strobe, majority-votes a window centred on mid-bit and
//   optionally re-zeroes the phase whenever the synchronised input toggles.
//
// Parameters
//   OVERSAMPLE  samples per bit (>= 4)
//   VOTE_WINDOW samples in the majority vote (odd, 1 .. OVERSAMPLE/2)
//   SYNC_STAGES flops in the input synchroniser (>= 1)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   raw_data       asynchronous serial input
//   sample_en      oversample strobe; phase/window/decision advance only when high
//   realign_en     allow input transitions to re-zero the bit phase
//   estimated_data last decided bit (registered, holds between decisions)
//   estimate_ready one-clk pulse the cycle after a decision
//   noise_flag     last vote was not unanimous (registered with estimate_ready)
module resync_bit_sampler #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned VOTE_WINDOW = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_data,
  input  logic sample_en,
  input  logic realign_en,
  output logic estimated_data,
  output logic estimate_ready,
  output logic noise_flag
);

  localparam int unsigned PHASE_W        = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W          = $clog2(VOTE_WINDOW + 1);
  localparam int unsigned DECISION_PHASE = OVERSAMPLE / 2 + VOTE_WINDOW / 2;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] DEC_PHASE  = PHASE_W'(DECISION_PHASE);
  localparam logic [CNT_W-1:0]   MAJORITY   = CNT_W'(VOTE_WINDOW / 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [VOTE_WINDOW-1:0] win_q, win_d, win_next;
  logic                   prev_q, prev_d;
  logic                   est_q, est_d;
  logic                   rdy_q, rdy_d;
  logic                   noise_q, noise_d;

  logic                   sync_data;
  logic                   realign_hit;
  logic                   decide;
  logic [CNT_W-1:0]       ones;

  // Synchroniser chain runs every clock; last stage feeds the sampler.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = raw_data;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_data = sync_q[SYNC_STAGES-1];

  // Window as it will look after this sample: newest sample at the LSB.
  always_comb begin
    win_next    = win_q;
    win_next[0] = sync_data;
    for (int unsigned i = 1; i < VOTE_WINDOW; i++) begin
      win_next[i] = win_q[i-1];
    end
  end

  // Population count of the window including the current sample.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < VOTE_WINDOW; i++) begin
      ones = ones + CNT_W'(win_next[i]);
    end
  end

  // A realign on the decision phase suppresses that cycle's decision.
  assign realign_hit = sample_en & realign_en & (sync_data != prev_q);
  assign decide      = sample_en & (phase_q == DEC_PHASE) & ~realign_hit;

  // Next-state logic for phase, window, previous sample and outputs.
  always_comb begin
    phase_d = phase_q;
    win_d   = win_q;
    prev_d  = prev_q;
    est_d   = est_q;
    noise_d = noise_q;
    rdy_d   = 1'b0;

    if (sample_en) begin
      win_d  = win_next;
      prev_d = sync_data;
      if (realign_hit) begin
        // The transition sample itself is phase 0.
        phase_d = PHASE_W'(1);
      end else if (phase_q == LAST_PHASE) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PHASE_W'(1);
      end
    end

    if (decide) begin
      est_d   = (ones > MAJORITY);
      noise_d = (win_next != '0) && (win_next != '1);
      rdy_d   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      phase_q <= '0;
      win_q   <= '0;
      prev_q  <= 1'b0;
      est_q   <= 1'b0;
      rdy_q   <= 1'b0;
      noise_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      phase_q <= phase_d;
      win_q   <= win_d;
      prev_q  <= prev_d;
      est_q   <= est_d;
      rdy_q   <= rdy_d;
      noise_q <= noise_d;
    end
  end

  assign estimated_data = est_q;
  assign estimate_ready = rdy_q;
  assign noise_flag     = noise_q;

endmodule

// File: tb/tb_resync_bit_sampler.sv
// Testbench for resync_bit_sampler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_resync_bit_sampler;

  localparam int OS = 16;
  localparam int VW = 3;
  localparam int SS = 2;
  localparam int DP = OS / 2 + VW / 2;

  logic clk = 1'b0;
  logic rst, raw_data, sample_en, realign_en;
  logic estimated_data, estimate_ready, noise_flag;

  always #5 clk = ~clk;

  resync_bit_sampler #(
    .OVERSAMPLE (OS),
    .VOTE_WINDOW(VW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_data      (raw_data),
    .sample_en     (sample_en),
    .realign_en    (realign_en),
    .estimated_data(estimated_data),
    .estimate_ready(estimate_ready),
    .noise_flag    (noise_flag)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: raw delayed through a queue, window as a queue of samples.
  bit m_sync[$];
  bit m_win[$];
  int m_phase;
  bit m_prev, m_data, m_rdy, m_noise;

  function automatic void model_reset();
    m_sync.delete();
    m_win.delete();
    repeat (SS) m_sync.push_back(1'b0);
    repeat (VW) m_win.push_back(1'b0);
    m_phase = 0;
    m_prev  = 1'b0;
    m_data  = 1'b0;
    m_rdy   = 1'b0;
    m_noise = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit d, bit en, bit ra);
    bit s;
    bit tr;
    int ones;
    if (r) begin
      model_reset();
      return;
    end
    s = m_sync.pop_front();
    m_sync.push_back(d);
    if (!en) begin
      m_rdy = 1'b0;
      return;
    end
    tr = ra && (s != m_prev);
    m_win.push_back(s);
    void'(m_win.pop_front());
    m_prev = s;
    if (m_phase == DP && !tr) begin
      ones = 0;
      foreach (m_win[i]) ones += int'(m_win[i]);
      m_data  = (ones > VW / 2);
      m_noise = (ones != 0) && (ones != VW);
      m_rdy   = 1'b1;
    end else begin
      m_rdy = 1'b0;
    end
    m_phase = tr ? 1 : (m_phase + 1) % OS;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare just after it.
  task automatic tick(input bit r, input bit d, input bit en, input bit ra);
    rst        = r;
    raw_data   = d;
    sample_en  = en;
    realign_en = ra;
    @(posedge clk);
    model_step(r, d, en, ra);
    #1;
    cyc++;
    chk("model_data",  estimated_data, m_data);
    chk("model_ready", estimate_ready, m_rdy);
    chk("model_noise", noise_flag,     m_noise);
  endtask

  initial begin
    int  last_pulse;
    int  n_pulse;
    int  en_cnt;
    bit  lvl;
    bit  glitched;
    bit  got;
    bit  d;

    model_reset();
    rst = 1'b1; raw_data = 1'b0; sample_en = 1'b0; realign_en = 1'b0;

    // Reset hold with toggling input.
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, bit'(i % 2), 1'b1, 1'b0);
      chk("rst_hold_data",  estimated_data, 1'b0);
      chk("rst_hold_ready", estimate_ready, 1'b0);
      chk("rst_hold_noise", noise_flag,     1'b0);
    end

    // Cadence with defaults: pulses after enabled edges 10, 26, 42.
    for (int e = 1; e <= 45; e++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("cadence_ready", estimate_ready, (e == 10 || e == 26 || e == 42));
      if (estimate_ready) begin
        chk("cadence_data",  estimated_data, 1'b0);
        chk("cadence_noise", noise_flag,     1'b0);
      end
    end

    // Strobe gating: enable on alternate cycles only.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    en_cnt = 0; n_pulse = 0; last_pulse = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 2 == 0) en_cnt++;
      tick(1'b0, 1'b0, bit'(c % 2 == 0), 1'b0);
      if (estimate_ready) begin
        if (n_pulse == 0) chk_int("gate_first_edge", en_cnt, 10);
        else              chk_int("gate_spacing", c - last_pulse, 32);
        last_pulse = c;
        n_pulse++;
      end
    end
    chk_int("gate_pulse_count", n_pulse, 3);

    // Noise vote: single-sample glitch landing at phase 8.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    glitched = 1'b0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      d = 1'b1;
      if (!glitched && m_phase == (8 - SS + OS) % OS) begin
        d = 1'b0;
        glitched = 1'b1;
      end
      tick(1'b0, d, 1'b1, 1'b0);
      if (glitched && d && estimate_ready) begin
        got = 1'b1;
        chk("noise_vote_data", estimated_data, 1'b1);
        chk("noise_vote_flag", noise_flag,     1'b1);
      end
    end
    chk_int("noise_vote_seen", int'(got), 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      if (estimate_ready) begin
        got = 1'b1;
        chk("noise_clear_data", estimated_data, 1'b0 ^ 1'b1);
        chk("noise_clear_flag", noise_flag,     1'b0);
      end
    end
    chk_int("noise_clear_seen", int'(got), 1);

    // Realignment at random phases, alternating transition direction.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    lvl = 1'b0;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 20 + int'($urandom_range(0, 15)); i++) tick(1'b0, lvl, 1'b1, 1'b1);
      lvl = ~lvl;
      for (int rel = 0; rel <= SS + 10; rel++) begin
        tick(1'b0, lvl, 1'b1, 1'b1);
        if (rel >= SS && rel <= SS + 8) chk("realign_quiet", estimate_ready, 1'b0);
        if (rel == SS + 9) begin
          chk("realign_pulse", estimate_ready, 1'b1);
          chk("realign_data",  estimated_data, lvl);
        end
        if (rel == SS + 10) chk("realign_width", estimate_ready, 1'b0);
      end
    end

    // Reset mid-operation at phase 5.
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16 && m_phase != 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    chk_int("midrst_phase_reached", m_phase, 5);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_data",  estimated_data, 1'b0);
    chk("midrst_ready", estimate_ready, 1'b0);
    chk("midrst_noise", noise_flag,     1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("midrst_cadence", estimate_ready, (e == 10));
    end

    // Randomized traffic against the model.
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      tick(bit'($urandom_range(0, 499) == 0), d,
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
